if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage, merged with the IF/ID pipeline register.
- Holds the PC and issues fetch requests to instruction memory over a req/gnt + rvalid handshake; one request outstanding at a time.
- Delivers {PC+4, instruction, valid} to decode in registers.
- Honours freeze (hazard stall) and branch redirect (flush) from later stages.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
PC_INC, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
freeze  in  1  hazard stall: hold the IF/ID outputs and stop advancing
branch_taken  in  1  redirect fetch to branch_addr and flush
branch_addr  in  32  branch target byte address
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; equals pc
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; earliest 1 cycle after gnt
imem_rdata  in  32  instruction word
PC  out  32  address of the delivered instruction + PC_INC
instruction  out  32  delivered instruction word
valid  out  1  PC/instruction hold a real instruction

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=S_REQ, hold buffer empty, PC=0, instruction=0, valid=0. Reset mid-transaction abandons it; a late rvalid after reset is ignored because state is S_REQ.
- States:
  - S_REQ: imem_req=1. On gnt, pc<=pc+PC_INC and go to S_WAIT; otherwise stay.
  - S_WAIT: wait for rvalid.
  - S_HOLD: response parked in the hold buffer.
  - S_DRAIN: discard one in-flight response.
- Definition: adv = !freeze.
- Response in S_WAIT (rvalid=1):
  - adv=1: on that edge, instruction<=rdata, PC<=req_addr+PC_INC, valid<=1. In the same cycle imem_req=1 with imem_addr=pc (back-to-back). Next state is S_WAIT if gnt, else S_REQ.
  - adv=0: park rdata and req_addr in the hold buffer and go to S_HOLD. No request is issued while the buffer is full.
- S_HOLD: on the first cycle with adv=1, the buffer moves to the outputs (valid<=1), the buffer empties, and the stage goes to S_REQ.
- Bubble: a cycle with adv=1 and nothing delivered sets valid<=0. PC and instruction keep their last values.
- Freeze: PC, instruction and valid hold exactly.
- Branch (branch_taken=1) has priority over freeze and over a same-cycle rvalid:
  - Outputs: valid<=0, instruction<=0; PC unchanged.
  - pc<=branch_addr; hold buffer cleared.
  - Next state: if a request is outstanding (S_WAIT with no rvalid this cycle), go to S_DRAIN; otherwise go to S_REQ.
  - imem_req=0 during a branch cycle, so no grant can be taken for a stale address.
- S_DRAIN: the next rvalid is dropped, then go to S_REQ. A second branch while in S_DRAIN updates pc and stays in S_DRAIN.
- Grant: gnt is ignored whenever imem_req=0.
- Address arithmetic: pc+PC_INC is mod 2^32. 32'hFFFF_FFFC wraps to 0.
- Latency: zero-wait memory (gnt same cycle, rvalid next cycle) delivers one instruction per cycle after a 2-cycle start-up from reset.

Decomposition:
- Shared package: state encoding (S_REQ, S_WAIT, S_HOLD, S_DRAIN), the 32-bit word width constant, and the PC_INC default.
- One sub-module is natural: if_hold_buffer, a one-entry {addr, data, full} register with load/clear/pop.

Test Plan:
1. Reset release with zero-wait memory returning addr as data:
   - Cycle 1: req, addr 0.
   - Cycle 2: valid=1, PC=4, instruction=0, and the next req has addr 4.
   - Then one instruction per cycle: PC=8, 12, 16.
2. freeze=1 for 3 cycles while a response arrives:
   - Outputs hold PC=8 and the hold buffer fills.
   - No req during the freeze.
   - After release: PC=12 next cycle, and req addr 12 one cycle later.
3. branch_taken=1 with branch_addr=32'h100 while a request for 0x20 is outstanding:
   - valid=0 next cycle.
   - The late rvalid (data 0x20) is dropped.
   - The next req has addr 0x100, and later PC=0x104.
4. branch_taken and freeze asserted together with rvalid in the same cycle:
   - Branch wins: valid=0, the hold buffer stays empty, and the next req is to the branch target.
5. Start at 32'hFFFF_FFFC (RESET_PC override):
   - PC output is 0, and the next req addr is 0 (wrap).
6. rst pulled low while in S_WAIT:
   - All outputs clear immediately, asynchronously.
   - After release, a req for RESET_PC is issued, and a stray rvalid in the first cycle is ignored.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, default
// PC increment, fetch FSM state encoding and the PC increment helper.
package if_fetch_stage_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] PC_INC_DEFAULT = 32'd4;

  // S_REQ  : requesting a fetch at pc
  // S_WAIT : one request granted, waiting for its response
  // S_HOLD : response parked in the hold buffer while decode is frozen
  // S_DRAIN: a flushed request is still in flight; its response is dropped
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  // Sequential address step; wraps naturally mod 2^32.
  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc,
                                                input logic [WORD_W-1:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry parking register for a fetch response that arrived while decode
// was frozen. Clear wins over load, load wins over pop.
module if_hold_buffer
  import if_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              pop,
  input  logic [WORD_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] data,
  output logic              full
);

  // Capture a parked response, or empty the entry on clear/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage merged with the IF/ID register. Keeps the fetch PC,
// talks to instruction memory with one request outstanding at a time, and
// presents {PC+PC_INC, instruction, valid} to decode. Freeze holds the
// outputs; a taken branch flushes and redirects fetch.
//
// Memory handshake: imem_req/imem_addr are a request that is accepted in any
// cycle where imem_req && imem_gnt; imem_gnt is meaningless while imem_req=0.
// The response for an accepted request is a single imem_rvalid pulse with
// imem_rdata, at least one cycle after the accepting cycle.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] instruction,
  output logic              valid,
  output logic [1:0]        dbg_state
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d;
  logic              adv;
  logic              deliver_wait;
  logic              deliver_hold;
  logic              hold_load;
  logic              hold_pop;
  logic              hold_clear;
  logic [WORD_W-1:0] hold_addr;
  logic [WORD_W-1:0] hold_data;
  logic              hold_full;

  assign adv       = !freeze;
  assign imem_addr = pc_q;
  assign dbg_state = state_q;

  if_hold_buffer u_hold (
    .clk       (clk),
    .rst_n     (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .pop       (hold_pop),
    .load_addr (req_addr_q),
    .load_data (imem_rdata),
    .addr      (hold_addr),
    .data      (hold_data),
    .full      (hold_full)
  );

  // FSM, fetch PC and request address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next-state, request and delivery decisions; branch always wins.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    imem_req     = 1'b0;
    deliver_wait = 1'b0;
    deliver_hold = 1'b0;
    hold_load    = 1'b0;
    hold_pop     = 1'b0;
    hold_clear   = branch_taken;
    case (state_q)
      S_REQ: begin
        if (branch_taken) begin
          pc_d = branch_addr;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            pc_d       = next_pc(pc_q, PC_INC);
            req_addr_d = pc_q;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          pc_d    = branch_addr;
          // A response arriving now closes the request; otherwise drain it.
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          if (adv) begin
            deliver_wait = 1'b1;
            imem_req     = 1'b1;
            if (imem_gnt) begin
              pc_d       = next_pc(pc_q, PC_INC);
              req_addr_d = pc_q;
              state_d    = S_WAIT;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_addr;
          state_d = S_REQ;
        end else if (adv) begin
          deliver_hold = hold_full;
          hold_pop     = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (branch_taken) begin
          pc_d = branch_addr;
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end else if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // IF/ID output register: flush, deliver, bubble, or hold under freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC          <= '0;
      instruction <= '0;
      valid       <= 1'b0;
    end else if (branch_taken) begin
      instruction <= '0;
      valid       <= 1'b0;
    end else if (deliver_wait) begin
      PC          <= next_pc(req_addr_q, PC_INC);
      instruction <= imem_rdata;
      valid       <= 1'b1;
    end else if (deliver_hold) begin
      PC          <= next_pc(hold_addr, PC_INC);
      instruction <= hold_data;
      valid       <= 1'b1;
    end else if (adv) begin
      valid <= 1'b0;
    end
  end

endmodule
